f2f_share_ctrl: RTL and testbench
=================================

Name: f2f_share_ctrl

Overview:
Round-robin scheduler that shares one combinational fixed_to_float converter instance between N_CH filter channels.
- Each channel offers a signed 16-bit integer sample with a valid/ready handshake.
- The block registers the granted sample, converts it, and presents the IEEE-754 single result with its channel tag on one valid/ready output stream.
- Sits between the filter channel outputs and the float-domain consumer.
- Also corrects the converter's boundary codes (0x0000, 0x8000).

Parameters:
N_CH, 4, number of requesting channels (2..16)
CH_W, $clog2(N_CH), channel tag width (derived, not overridden)

Ports:
i_clk  in  1  clock, all logic on rising edge
i_rst  in  1  synchronous active-high reset
i_valid  in  N_CH  per-channel sample valid
i_fixed  in  16*N_CH  per-channel signed sample; channel k at [16k+15:16k]
o_ready  out  N_CH  per-channel accept; at most one bit high per cycle
o_valid  out  1  output float valid
o_float  out  32  converted IEEE-754 single
o_ch  out  CH_W  channel index of o_float
i_ready  in  1  downstream accept
o_count  out  16  count of results delivered (o_valid&&i_ready), wraps 0xFFFF->0

Behaviour:
- Reset (i_rst high at edge):
  - s1_valid=0, o_valid=0, o_float=0, o_ch=0, o_count=0.
  - Round-robin pointer last=N_CH-1, so channel 0 wins first.
  - o_ready is forced to all-zero while i_rst is high.
- Pipeline: two register stages.
  - S1 holds {sample, ch, s1_valid}.
  - S2 holds the output registers {o_float, o_ch, o_valid}.
- Advance rules:
  - adv2 = !o_valid || i_ready.
  - adv1 = !s1_valid || adv2.
  - S2 loads S1 when adv2; o_valid takes s1_valid.
  - S1 loads the grant when adv1; s1_valid is set to (any grant).
- Grant arbitration:
  - Search i_valid from last+1 upward, wrapping modulo N_CH; the first set bit wins.
  - o_ready[win] = adv1 && !i_rst; all other o_ready bits are 0.
  - last updates to win only on accept (i_valid[win] && o_ready[win]).
- Latency:
  - A sample accepted at edge t appears with o_valid=1 after edge t+1 (two register loads) when unstalled.
  - Sustained throughput is 1 result per cycle.
- Stall:
  - While o_valid && !i_ready: o_float, o_ch and o_valid hold.
  - S1 holds if full; no o_ready is asserted if S1 is full.
- Fairness: with all channels valid continuously, grants go 0,1,..,N_CH-1,0,...; no channel waits more than N_CH accepts.
- Handshake rules:
  - An upstream channel may drop i_valid without penalty.
  - The grant is recomputed every cycle; there is no lock.
- Conversion (combinational between S1 and S2, through the shared converter):
  - Sample 0x0000: force o_float=32'h0000_0000. The converter has no zero case.
  - Sample 0x8000: force o_float=32'hC700_0000 (-32768.0). The converter cannot represent 2^15 magnitude.
  - All other samples: use the converter output unchanged. Value v maps to float v.0 exactly; no rounding is needed for 16-bit integers.
- o_count increments on each cycle with o_valid && i_ready; it wraps silently.
- Reset mid-operation: in-flight S1/S2 data is discarded, no output handshake completes in the reset cycle, and the pointer returns to N_CH-1.
- Simultaneous events: S2 consume and S1 refill in the same cycle is legal and required for full throughput.

Decomposition:
- Package f2f_pkg:
  - FIXED_W=16, FLOAT_W=32.
  - FLOAT_ZERO=32'h0, FLOAT_NEG_MIN=32'hC700_0000, FIXED_NEG_MIN=16'h8000.
  - Typedef s1_entry_t {logic [15:0] sample; logic [3:0] ch;}.
- Sub-module rr_arbiter (N parameter): inputs req, last, enable; output one-hot grant plus index.
- Top module: S1/S2 registers, boundary-code override, counter, one converter instance.

Test Plan:
- Reset, then ch0 i_valid with i_fixed=0x0001, i_ready=1 -> o_ready[0]=1 on first cycle; two edges later o_valid=1, o_float=0x3F80_0000, o_ch=0, o_count=1 one cycle after.
- All 4 channels valid, samples 3, -1 (0xFFFF), 100, 0x7FFF, i_ready=1 -> outputs on consecutive cycles in order:
  - ch0 0x4040_0000
  - ch1 0xBF80_0000
  - ch2 0x42C8_0000
  - ch3 0x46FF_FE00
  - then ch0 again.
- Boundary codes: ch1 0x0000 then 0x8000 -> o_float 0x0000_0000 then 0xC700_0000, o_ch=1 both.
- Backpressure: i_ready=0 for 5 cycles with all channels valid -> o_float/o_ch stable; after S1 fills, all o_ready=0. On i_ready=1, results drain in order with none lost or duplicated.
- Fairness/skip: only ch2 and ch3 valid, alternating -> grants 2,3,2,3; ch0 and ch1 never get o_ready.
- Reset mid-stream: i_rst high for 1 cycle while S1 and S2 are full -> o_valid=0 and o_count=0 next cycle, o_ready all 0 during reset; the next grant goes to ch0 if valid.

Source files
------------

// File: rtl/f2f_share_ctrl_pkg.sv
// Shared constants and types for the fixed-to-float sharing controller.
package f2f_pkg;
  localparam int FIXED_W = 16;
  localparam int FLOAT_W = 32;

  localparam logic [FLOAT_W-1:0] FLOAT_ZERO    = 32'h0000_0000;
  localparam logic [FLOAT_W-1:0] FLOAT_NEG_MIN = 32'hC700_0000;
  localparam logic [FIXED_W-1:0] FIXED_NEG_MIN = 16'h8000;

  typedef struct packed {
    logic [FIXED_W-1:0] sample;
    logic [3:0]         ch;
  } s1_entry_t;
endpackage

// File: rtl/f2f_share_ctrl_if.sv
// Channel-side and float-side handshake bundle for f2f_share_ctrl.
interface f2f_share_ctrl_if #(
  parameter int N_CH = 4
) ();
  localparam int CH_W = $clog2(N_CH);

  logic [N_CH-1:0]    i_valid;
  logic [16*N_CH-1:0] i_fixed;
  logic [N_CH-1:0]    o_ready;
  logic               o_valid;
  logic [31:0]        o_float;
  logic [CH_W-1:0]    o_ch;
  logic               i_ready;
  logic [15:0]        o_count;

  modport slave (
    input  i_valid, i_fixed, i_ready,
    output o_ready, o_valid, o_float, o_ch, o_count
  );

  modport master (
    output i_valid, i_fixed, i_ready,
    input  o_ready, o_valid, o_float, o_ch, o_count
  );
endinterface

// File: rtl/f2f_share_ctrl_fixed_to_float.sv
// Combinational signed 16-bit integer to IEEE-754 single converter.
// Zero and -32768 are not handled here; the caller overrides those codes.
module f2f_share_ctrl_fixed_to_float
  import f2f_pkg::*;
(
  input  logic [FIXED_W-1:0] fixed_i,
  output logic [FLOAT_W-1:0] float_o
);
  logic        neg;
  logic [14:0] mag;
  logic [3:0]  msb;
  logic [13:0] frac;
  logic [7:0]  expo;

  always_comb begin
    neg  = fixed_i[15];
    mag  = neg ? (~fixed_i[14:0] + 15'd1) : fixed_i[14:0];
    msb  = 4'd0;
    for (int i = 0; i < 15; i++) begin
      if (mag[i]) msb = 4'(i);
    end
    // normalise so the leading one lands on bit 14, then drop it
    frac    = 14'(mag << (4'd14 - msb));
    expo    = 8'd127 + {4'd0, msb};
    float_o = {neg, expo, frac, 9'd0};
  end
endmodule

// File: rtl/f2f_share_ctrl_rr_arbiter.sv
// Round-robin arbiter: first request strictly after 'last', wrapping.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] last_i,
  input  logic             enable_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             found_o
);
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = 1; i <= N; i++) begin
      if (!found_o && req_i[(int'(last_i) + i) % N]) begin
        found_o = 1'b1;
        idx_o   = IDX_W'((int'(last_i) + i) % N);
      end
    end
    grant_o = (found_o && enable_i) ? ({{(N-1){1'b0}}, 1'b1} << idx_o) : '0;
  end
endmodule

// File: rtl/f2f_share_ctrl.sv
// Shares one fixed_to_float converter across N_CH channels through a
// two-stage pipeline with round-robin grant and boundary-code correction.
module f2f_share_ctrl
  import f2f_pkg::*;
#(
  parameter  int N_CH = 4,
  localparam int CH_W = $clog2(N_CH)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  f2f_share_ctrl_if.slave bus
);
  s1_entry_t          s1_q, s1_d;
  logic               s1_valid_q, s1_valid_d;
  logic [CH_W-1:0]    last_q, last_d;
  logic [FLOAT_W-1:0] o_float_q, o_float_d;
  logic [CH_W-1:0]    o_ch_q, o_ch_d;
  logic               o_valid_q, o_valid_d;
  logic [15:0]        count_q, count_d;

  logic               adv1, adv2, arb_en, found, accept;
  logic [CH_W-1:0]    win_idx;
  logic [N_CH-1:0]    grant;
  logic [FIXED_W-1:0] win_sample;
  logic [FLOAT_W-1:0] conv_out, conv_fix;
  logic               unused_ch;

  assign adv2   = !o_valid_q || bus.i_ready;
  assign adv1   = !s1_valid_q || adv2;
  assign arb_en = adv1 && !i_rst;
  assign accept = found && arb_en;

  rr_arbiter #(.N(N_CH), .IDX_W(CH_W)) u_arb (
    .req_i    (bus.i_valid),
    .last_i   (last_q),
    .enable_i (arb_en),
    .grant_o  (grant),
    .idx_o    (win_idx),
    .found_o  (found)
  );

  assign win_sample = bus.i_fixed[int'(win_idx)*FIXED_W +: FIXED_W];

  f2f_share_ctrl_fixed_to_float u_conv (
    .fixed_i (s1_q.sample),
    .float_o (conv_out)
  );

  // the converter has no zero case and cannot express a 2^15 magnitude
  always_comb begin
    conv_fix = conv_out;
    if (s1_q.sample == '0)                conv_fix = FLOAT_ZERO;
    else if (s1_q.sample == FIXED_NEG_MIN) conv_fix = FLOAT_NEG_MIN;
  end

  assign unused_ch = ^s1_q.ch;

  always_comb begin
    s1_d       = s1_q;
    s1_valid_d = s1_valid_q;
    last_d     = last_q;
    o_float_d  = o_float_q;
    o_ch_d     = o_ch_q;
    o_valid_d  = o_valid_q;
    count_d    = count_q;
    if (adv1) begin
      s1_valid_d = accept;
      if (accept) begin
        s1_d.sample = win_sample;
        s1_d.ch     = 4'(win_idx);
        last_d      = win_idx;
      end
    end
    if (adv2) begin
      o_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        o_float_d = conv_fix;
        o_ch_d    = s1_q.ch[CH_W-1:0];
      end
    end
    if (o_valid_q && bus.i_ready) count_d = count_q + 16'd1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_q       <= '0;
      s1_valid_q <= 1'b0;
      last_q     <= CH_W'(N_CH - 1);
      o_float_q  <= '0;
      o_ch_q     <= '0;
      o_valid_q  <= 1'b0;
      count_q    <= '0;
    end else begin
      s1_q       <= s1_d;
      s1_valid_q <= s1_valid_d;
      last_q     <= last_d;
      o_float_q  <= o_float_d;
      o_ch_q     <= o_ch_d;
      o_valid_q  <= o_valid_d;
      count_q    <= count_d;
    end
  end

  assign bus.o_ready = grant;
  assign bus.o_valid = o_valid_q;
  assign bus.o_float = o_float_q;
  assign bus.o_ch    = o_ch_q;
  assign bus.o_count = count_q;
endmodule

// File: tb/tb_f2f_share_ctrl.sv
// Randomised and directed bench for f2f_share_ctrl against a queue-based model.
module tb_f2f_share_ctrl;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  f2f_share_ctrl_if #(.N_CH(N)) bus ();

  f2f_share_ctrl #(.N_CH(N)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          ch;
    logic [31:0] fl;
    int          cyc;
  } item_t;

  item_t       q[$];
  int          last_m = N - 1;
  int          cnt_m  = 0;
  int          cyc_m  = 0;
  logic [3:0]  exp_ready;
  logic        exp_ov;
  logic [31:0] exp_fl;
  logic [1:0]  exp_ch;

  function automatic logic [31:0] ref_float(input logic [15:0] x);
    int sv, mag, e, frac;
    logic sgn;
    sv = int'($signed(x));
    if (sv == 0) return 32'h0;
    sgn = (sv < 0);
    mag = sgn ? -sv : sv;
    e = 0;
    while ((mag >> (e + 1)) != 0) e++;
    frac = (mag - (1 << e)) << (23 - e);
    return {sgn, 8'(127 + e), 23'(frac)};
  endfunction

  // pipeline room exists when fewer than two results are in flight
  // or the oldest one is leaving this cycle
  task automatic model_eval();
    exp_ov = (q.size() > 0) && (q[0].cyc < cyc_m);
    exp_fl = exp_ov ? q[0].fl : 32'h0;
    exp_ch = exp_ov ? 2'(q[0].ch) : 2'd0;
    exp_ready = '0;
    if (!rst && (q.size() < 2 || (exp_ov && bus.i_ready))) begin
      for (int i = 1; i <= N; i++) begin
        int c;
        c = (last_m + i) % N;
        if (exp_ready == 0 && bus.i_valid[c]) exp_ready[c] = 1'b1;
      end
    end
  endtask

  task automatic tick();
    model_eval();
    if (rst) begin
      q.delete();
      last_m = N - 1;
      cnt_m  = 0;
    end else begin
      if (exp_ov && bus.i_ready) begin
        void'(q.pop_front());
        cnt_m = (cnt_m + 1) & 16'hFFFF;
      end
      for (int c = 0; c < N; c++) begin
        if (exp_ready[c] && bus.i_valid[c]) begin
          q.push_back('{ch: c, fl: ref_float(bus.i_fixed[16*c +: 16]), cyc: cyc_m + 1});
          last_m = c;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc_m++;
  endtask

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.i_valid = '0;
    bus.i_ready = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_valid = '1;
    bus.i_fixed = {4{16'h1234}};
    bus.i_ready = 1'b1;
    settle();
    checks++; if (bus.o_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got=%b exp=0000", bus.o_ready); end
    tick();
    bus.i_valid = '0;
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL reset_ovalid got=%b exp=0", bus.o_valid); end
    checks++; if (bus.o_float !== 32'h0) begin errors++; $display("FAIL reset_ofloat got=%h exp=0", bus.o_float); end
    checks++; if (bus.o_ch !== 2'd0) begin errors++; $display("FAIL reset_och got=%0d exp=0", bus.o_ch); end
    checks++; if (bus.o_count !== 16'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", bus.o_count); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    bus.i_valid = 4'b0001;
    bus.i_fixed = {16'h0, 16'h0, 16'h0, 16'h0001};
    bus.i_ready = 1'b1;
    settle();
    checks++; if (bus.o_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got=%b exp=0001", bus.o_ready); end
    tick();
    bus.i_valid = '0;
    settle();
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL single_lat1 got=%b exp=0", bus.o_valid); end
    tick();
    settle();
    checks++; if (bus.o_valid !== 1'b1 || bus.o_float !== 32'h3F80_0000 || bus.o_ch !== 2'd0)
      begin errors++; $display("FAIL single_out got=%b/%h/%0d exp=1/3f800000/0", bus.o_valid, bus.o_float, bus.o_ch); end
    checks++; if (bus.o_count !== 16'd0) begin errors++; $display("FAIL single_cnt0 got=%0d exp=0", bus.o_count); end
    tick();
    checks++; if (bus.o_count !== 16'd1 || bus.o_valid !== 1'b0)
      begin errors++; $display("FAIL single_cnt1 got=%0d/%b exp=1/0", bus.o_count, bus.o_valid); end
  endtask

  task automatic test_order();
    logic [31:0] tbl [4];
    int k;
    tbl[0] = 32'h4040_0000; tbl[1] = 32'hBF80_0000;
    tbl[2] = 32'h42C8_0000; tbl[3] = 32'h46FF_FE00;
    k = 0;
    do_reset();
    bus.i_valid = 4'b1111;
    bus.i_fixed = {16'h7FFF, 16'd100, 16'hFFFF, 16'd3};
    bus.i_ready = 1'b1;
    for (int it = 0; it < 10; it++) begin
      settle();
      checks++; if (bus.o_ready !== exp_ready) begin errors++; $display("FAIL order_ready it=%0d got=%b exp=%b", it, bus.o_ready, exp_ready); end
      if (bus.o_valid) begin
        checks++; if (bus.o_float !== tbl[k%4] || bus.o_ch !== 2'(k%4))
          begin errors++; $display("FAIL order_out k=%0d got=%h/%0d exp=%h/%0d", k, bus.o_float, bus.o_ch, tbl[k%4], k%4); end
        k++;
      end
      tick();
    end
    checks++; if (k != 8) begin errors++; $display("FAIL order_count got=%0d exp=8", k); end
    bus.i_valid = '0;
  endtask

  task automatic test_boundary();
    do_reset();
    bus.i_ready = 1'b1;
    bus.i_valid = 4'b0010;
    bus.i_fixed = {16'h0, 16'h0, 16'h0000, 16'h0};
    settle();
    checks++; if (bus.o_ready !== 4'b0010) begin errors++; $display("FAIL bnd_ready got=%b exp=0010", bus.o_ready); end
    tick();
    bus.i_fixed = {16'h0, 16'h0, 16'h8000, 16'h0};
    tick();
    bus.i_valid = '0;
    settle();
    checks++; if (bus.o_valid !== 1'b1 || bus.o_float !== 32'h0 || bus.o_ch !== 2'd1)
      begin errors++; $display("FAIL bnd_zero got=%b/%h/%0d exp=1/00000000/1", bus.o_valid, bus.o_float, bus.o_ch); end
    tick();
    settle();
    checks++; if (bus.o_valid !== 1'b1 || bus.o_float !== 32'hC700_0000 || bus.o_ch !== 2'd1)
      begin errors++; $display("FAIL bnd_negmin got=%b/%h/%0d exp=1/c7000000/1", bus.o_valid, bus.o_float, bus.o_ch); end
    tick();
  endtask

  task automatic test_backpressure();
    logic [31:0] held_f;
    logic [1:0]  held_c;
    do_reset();
    bus.i_valid = 4'b1111;
    bus.i_fixed = {16'd40, 16'hFF00, 16'd7, 16'd1234};
    bus.i_ready = 1'b1;
    tick();
    tick();
    bus.i_ready = 1'b0;
    settle();
    held_f = bus.o_float;
    held_c = bus.o_ch;
    checks++; if (bus.o_valid !== 1'b1 || bus.o_float !== exp_fl || bus.o_ch !== exp_ch)
      begin errors++; $display("FAIL bp_first got=%b/%h/%0d exp=1/%h/%0d", bus.o_valid, bus.o_float, bus.o_ch, exp_fl, exp_ch); end
    for (int it = 0; it < 5; it++) begin
      settle();
      checks++; if (bus.o_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready it=%0d got=%b exp=0000", it, bus.o_ready); end
      checks++; if (bus.o_valid !== 1'b1 || bus.o_float !== held_f || bus.o_ch !== held_c)
        begin errors++; $display("FAIL bp_hold it=%0d got=%h/%0d exp=%h/%0d", it, bus.o_float, bus.o_ch, held_f, held_c); end
      tick();
    end
    bus.i_ready = 1'b1;
    bus.i_valid = '0;
    for (int it = 0; it < 4; it++) begin
      settle();
      checks++; if (bus.o_valid !== exp_ov || (exp_ov && (bus.o_float !== exp_fl || bus.o_ch !== exp_ch)))
        begin errors++; $display("FAIL bp_drain it=%0d got=%b/%h/%0d exp=%b/%h/%0d", it, bus.o_valid, bus.o_float, bus.o_ch, exp_ov, exp_fl, exp_ch); end
      tick();
    end
    checks++; if (q.size() != 0 || bus.o_count !== 16'(cnt_m))
      begin errors++; $display("FAIL bp_empty left=%0d cnt=%0d exp_cnt=%0d", q.size(), bus.o_count, cnt_m); end
  endtask

  task automatic test_skip();
    logic [3:0] seq [4];
    seq[0] = 4'b0100; seq[1] = 4'b1000; seq[2] = 4'b0100; seq[3] = 4'b1000;
    do_reset();
    bus.i_valid = 4'b1100;
    bus.i_fixed = {16'd9, 16'd8, 16'd5, 16'd4};
    bus.i_ready = 1'b1;
    for (int it = 0; it < 4; it++) begin
      settle();
      checks++; if (bus.o_ready !== seq[it] || bus.o_ready !== exp_ready)
        begin errors++; $display("FAIL skip_grant it=%0d got=%b exp=%b", it, bus.o_ready, seq[it]); end
      tick();
    end
    bus.i_valid = '0;
    tick(); tick();
  endtask

  task automatic test_reset_midstream();
    bus.i_valid = 4'b1111;
    bus.i_fixed = {16'd11, 16'd22, 16'd33, 16'd44};
    bus.i_ready = 1'b1;
    tick();
    bus.i_ready = 1'b0;
    tick(); tick();
    settle();
    checks++; if (bus.o_valid !== 1'b1) begin errors++; $display("FAIL mid_full got=%b exp=1", bus.o_valid); end
    rst = 1'b1;
    bus.i_ready = 1'b1;
    settle();
    checks++; if (bus.o_ready !== 4'b0000) begin errors++; $display("FAIL mid_rst_ready got=%b exp=0000", bus.o_ready); end
    tick();
    rst = 1'b0;
    settle();
    checks++; if (bus.o_valid !== 1'b0 || bus.o_count !== 16'd0)
      begin errors++; $display("FAIL mid_after got=%b/%0d exp=0/0", bus.o_valid, bus.o_count); end
    checks++; if (bus.o_ready !== 4'b0001) begin errors++; $display("FAIL mid_grant got=%b exp=0001", bus.o_ready); end
    tick();
    bus.i_valid = '0;
    tick(); tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int it = 0; it < 400; it++) begin
      bus.i_valid = 4'($urandom_range(0, 15));
      for (int c = 0; c < N; c++) begin
        case ($urandom_range(0, 9))
          0:       bus.i_fixed[16*c +: 16] = 16'h0000;
          1:       bus.i_fixed[16*c +: 16] = 16'h8000;
          default: bus.i_fixed[16*c +: 16] = 16'($urandom);
        endcase
      end
      bus.i_ready = ($urandom_range(0, 9) < 7);
      rst = ($urandom_range(0, 99) == 0);
      settle();
      checks++; if (bus.o_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready it=%0d got=%b exp=%b", it, bus.o_ready, exp_ready); end
      checks++; if (bus.o_valid !== exp_ov || (exp_ov && (bus.o_float !== exp_fl || bus.o_ch !== exp_ch)))
        begin errors++; $display("FAIL rnd_out it=%0d got=%b/%h/%0d exp=%b/%h/%0d", it, bus.o_valid, bus.o_float, bus.o_ch, exp_ov, exp_fl, exp_ch); end
      checks++; if (bus.o_count !== 16'(cnt_m)) begin errors++; $display("FAIL rnd_count it=%0d got=%0d exp=%0d", it, bus.o_count, cnt_m); end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    bus.i_valid = '0;
    bus.i_fixed = '0;
    bus.i_ready = 1'b1;
    #2;
    test_reset();
    test_single();
    test_order();
    test_boundary();
    test_backpressure();
    test_skip();
    test_reset_midstream();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
